// File: rtl/soc_slot_fabric.sv
// rtl/soc_slot_fabric.sv - address decode, write routing, registered read mux and sticky done flags (optional irq: SOC_FABRIC_IRQ_EN)
module soc_slot_fabric #(
  parameter int          NUM_SLOTS   = 4,
  parameter int          DW          = 32,
  parameter logic [31:0] MEM_TOP     = 32'h0000_0800,
  parameter logic [31:0] SLOT_BASE   = 32'h0000_0800,
  parameter logic [31:0] SLOT_STRIDE = 32'h0000_0200,
  parameter logic [31:0] STATUS_ADDR = 32'h0000_1F00
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             addr,
  input  logic [DW-1:0]           wdata,
  input  logic                    we,
  input  logic                    re,
  output logic [DW-1:0]           rdata,
  output logic                    rvalid,
  output logic                    err,
  output logic                    mem_we,
  input  logic [DW-1:0]           mem_rdata,
  output logic [NUM_SLOTS-1:0]    slot_we,
  output logic [1:0]              slot_a,
  input  logic [NUM_SLOTS*DW-1:0] slot_rdata,
  input  logic [NUM_SLOTS-1:0]    slot_done,
  output logic [NUM_SLOTS-1:0]    done_flags
`ifdef SOC_FABRIC_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam logic [31:0] SLOT_END = SLOT_BASE + NUM_SLOTS * SLOT_STRIDE;

  // Parameter sanity: slot window must not swallow the status register.
  if (NUM_SLOTS < 1 || NUM_SLOTS > 8) begin : g_num_slots_err
    $error("soc_slot_fabric: NUM_SLOTS must be 1..8");
  end
  if (STATUS_ADDR >= SLOT_BASE && STATUS_ADDR < SLOT_END) begin : g_overlap_err
    $error("soc_slot_fabric: STATUS_ADDR overlaps slot address space");
  end

  logic                 mem_hit;
  logic                 in_slots;
  logic [NUM_SLOTS-1:0] slot_hit;
  logic                 status_hit;
  logic                 mask_hit;
  logic                 none_hit;
  logic [31:0]          slot_off;
  logic [31:0]          slot_idx;
  logic [DW-1:0]        rd_src;
  logic [NUM_SLOTS-1:0] done_q;
  logic [NUM_SLOTS-1:0] done_rise;
  logic [NUM_SLOTS-1:0] done_clr;
  logic [NUM_SLOTS-1:0] irq_mask_val;

  // Upper write-data bits only matter to the targets, not to the fabric.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

`ifdef SOC_FABRIC_IRQ_EN
  logic [NUM_SLOTS-1:0] irq_mask;
  assign irq_mask_val = irq_mask;
`else
  assign irq_mask_val = '0;
`endif

  // Address decode: exactly one target (or none) is selected per access.
  always_comb begin
    slot_off   = addr - SLOT_BASE;
    slot_idx   = slot_off / SLOT_STRIDE;
    mem_hit    = (addr < MEM_TOP);
    in_slots   = !mem_hit && (addr >= SLOT_BASE) && (slot_idx < 32'(NUM_SLOTS));
    slot_hit   = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slot_hit[k] = in_slots && (slot_idx == 32'(k));
    end
    status_hit = !mem_hit && !in_slots && (addr == STATUS_ADDR);
`ifdef SOC_FABRIC_IRQ_EN
    mask_hit   = !mem_hit && !in_slots && (addr == STATUS_ADDR + 32'd4);
`else
    mask_hit   = 1'b0;
`endif
    none_hit   = !(mem_hit || in_slots || status_hit || mask_hit);
  end

  assign mem_we  = we & mem_hit;
  assign slot_we = {NUM_SLOTS{we}} & slot_hit;
  assign slot_a  = addr[3:2];

  // Read source mux; status and mask read back their pre-edge values.
  always_comb begin
    rd_src = '0;
    if (mem_hit) rd_src = mem_rdata;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_hit[k]) rd_src = slot_rdata[k*DW +: DW];
    end
    if (status_hit) rd_src = DW'(done_flags);
    if (mask_hit)   rd_src = DW'(irq_mask_val);
  end

  // Flag set on rising done; cleared by slot access or W1C to status.
  always_comb begin
    done_rise = slot_done & ~done_q;
    done_clr  = {NUM_SLOTS{we | re}} & slot_hit;
    if (we && status_hit) done_clr = done_clr | wdata[NUM_SLOTS-1:0];
  end

  // Read response, error pulse and done-flag state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata      <= '0;
      rvalid     <= 1'b0;
      err        <= 1'b0;
      done_q     <= '0;
      done_flags <= '0;
    end else begin
      rvalid     <= re;
      err        <= (we | re) & none_hit;
      if (re) rdata <= rd_src;
      done_q     <= slot_done;
      done_flags <= (done_flags & ~done_clr) | done_rise;
    end
  end

`ifdef SOC_FABRIC_IRQ_EN
  // Interrupt mask register and registered interrupt output.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (we && mask_hit) irq_mask <= wdata[NUM_SLOTS-1:0];
      irq <= |(done_flags & irq_mask);
    end
  end
`endif

endmodule

// File: tb/tb_soc_slot_fabric.sv
// tb/tb_soc_slot_fabric.sv - directed self-checking bench for soc_slot_fabric
module tb_soc_slot_fabric;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic         we;
  logic         re;
  logic [31:0]  rdata;
  logic         rvalid;
  logic         err;
  logic         mem_we;
  logic [31:0]  mem_rdata;
  logic [3:0]   slot_we;
  logic [1:0]   slot_a;
  logic [127:0] slot_rdata;
  logic [3:0]   slot_done;
  logic [3:0]   done_flags;
`ifdef SOC_FABRIC_IRQ_EN
  logic         irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  soc_slot_fabric dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .wdata      (wdata),
    .we         (we),
    .re         (re),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .err        (err),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .slot_we    (slot_we),
    .slot_a     (slot_a),
    .slot_rdata (slot_rdata),
    .slot_done  (slot_done),
    .done_flags (done_flags)
`ifdef SOC_FABRIC_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    we = 1'b0;
    re = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    addr       = '0;
    wdata      = '0;
    we         = 1'b0;
    re         = 1'b0;
    mem_rdata  = '0;
    slot_rdata = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    slot_done  = '0;
    tick();
    tick();
    check("rst_rdata",  rdata,      32'h0);
    check("rst_rvalid", {31'b0, rvalid}, 32'h0);
    check("rst_err",    {31'b0, err},    32'h0);
    check("rst_flags",  {28'b0, done_flags}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // 1: status read after reset
    @(negedge clk);
    addr = 32'h1F00; re = 1'b1;
    tick();
    check("t1_rvalid", {31'b0, rvalid}, 32'h1);
    check("t1_rdata",  rdata, 32'h0);
    check("t1_flags",  {28'b0, done_flags}, 32'h0);
    idle();
    tick();
    check("t1_rvalid_pulse", {31'b0, rvalid}, 32'h0);
    check("t1_rdata_hold",   rdata, 32'h0);

    // 2: dmem write then read
    @(negedge clk);
    addr = 32'h10; wdata = 32'hDEAD_BEEF; we = 1'b1;
    #1;
    check("t2_mem_we",  {31'b0, mem_we}, 32'h1);
    check("t2_slot_we", {28'b0, slot_we}, 32'h0);
    @(negedge clk);
    we = 1'b0; re = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("t2_mem_we_rd", {31'b0, mem_we}, 32'h0);
    tick();
    check("t2_rdata",  rdata, 32'hDEAD_BEEF);
    check("t2_rvalid", {31'b0, rvalid}, 32'h1);
    idle();

    // slot write decode: 0xC04 -> slot 2, word 1
    @(negedge clk);
    addr = 32'hC04; wdata = 32'h5; we = 1'b1;
    #1;
    check("sw_slot_we", {28'b0, slot_we}, 32'h4);
    check("sw_mem_we",  {31'b0, mem_we}, 32'h0);
    check("sw_slot_a",  {30'b0, slot_a}, 32'h1);
    idle();

    // 3: done rising edge, status read, slot read clears
    @(negedge clk);
    slot_done = 4'b0010;
    tick();
    check("t3_flag_set", {28'b0, done_flags}, 32'h2);
    @(negedge clk);
    addr = 32'h1F00; re = 1'b1;
    tick();
    check("t3_status_rd", rdata, 32'h2);
    @(negedge clk);
    addr = 32'hA08; re = 1'b1;
    #1;
    check("t3_slot_a", {30'b0, slot_a}, 32'h2);
    tick();
    check("t3_slot_rdata", rdata, 32'h2222_0001);
    check("t3_flag_clr",   {28'b0, done_flags}, 32'h0);
    idle();
    tick();
    tick();
    check("t3_level_no_reset", {28'b0, done_flags}, 32'h0);

    // 4: set wins over same-cycle W1C
    @(negedge clk);
    slot_done = 4'b0110; addr = 32'h1F00; wdata = 32'h4; we = 1'b1;
    #1;
    check("t4_status_mem_we", {31'b0, mem_we}, 32'h0);
    tick();
    check("t4_set_wins", {28'b0, done_flags}, 32'h4);
    tick();
    check("t4_w1c", {28'b0, done_flags}, 32'h0);
    idle();

    // simultaneous we & re on status: read sees pre-clear value
    @(negedge clk);
    slot_done = 4'b1110;
    tick();
    check("sim_flag_set", {28'b0, done_flags}, 32'h8);
    @(negedge clk);
    addr = 32'h1F00; wdata = 32'h8; we = 1'b1; re = 1'b1;
    tick();
    check("sim_rdata_pre", rdata, 32'h8);
    check("sim_flag_clr",  {28'b0, done_flags}, 32'h0);
    idle();

    // 5: unmapped read
    @(negedge clk);
    addr = 32'h1800; re = 1'b1;
    tick();
    check("t5_err",    {31'b0, err}, 32'h1);
    check("t5_rdata",  rdata, 32'h0);
    check("t5_rvalid", {31'b0, rvalid}, 32'h1);
    idle();
    tick();
    check("t5_err_pulse", {31'b0, err}, 32'h0);

    // 5b: write to STATUS_ADDR+4 with a flag pending
    @(negedge clk);
    slot_done = 4'b0000;
    tick();
    @(negedge clk);
    slot_done = 4'b1000;
    tick();
    check("t5b_flag_set", {28'b0, done_flags}, 32'h8);
    @(negedge clk);
    addr = 32'h1F04; wdata = 32'hFFFF_FFFF; we = 1'b1;
    #1;
    check("t5b_mem_we",  {31'b0, mem_we}, 32'h0);
    check("t5b_slot_we", {28'b0, slot_we}, 32'h0);
    tick();
`ifdef SOC_FABRIC_IRQ_EN
    check("t6_mask_err", {31'b0, err}, 32'h0);
    check("t6_flags",    {28'b0, done_flags}, 32'h8);
    check("t6_irq_lag",  {31'b0, irq}, 32'h0);
    idle();
    tick();
    check("t6_irq_set", {31'b0, irq}, 32'h1);
    @(negedge clk);
    addr = 32'h1F04; re = 1'b1;
    tick();
    check("t6_mask_rd", rdata, 32'hF);
    @(negedge clk);
    re = 1'b0; addr = 32'h1F00; wdata = 32'h8; we = 1'b1;
    tick();
    check("t6_w1c_flags", {28'b0, done_flags}, 32'h0);
    idle();
    tick();
    check("t6_irq_clr", {31'b0, irq}, 32'h0);
`else
    check("t5b_err",   {31'b0, err}, 32'h1);
    check("t5b_flags", {28'b0, done_flags}, 32'h8);
    idle();
    @(negedge clk);
    addr = 32'h1F04; re = 1'b1;
    tick();
    check("t5b_rd_err",   {31'b0, err}, 32'h1);
    check("t5b_rd_rdata", rdata, 32'h0);
    idle();
`endif

    // reset with a read pending; done held high through reset
    @(negedge clk);
    slot_done = 4'b0001; addr = 32'h10; re = 1'b1; reset = 1'b1;
    tick();
    check("rst_rvalid_drop", {31'b0, rvalid}, 32'h0);
    check("rst_flags_mid",   {28'b0, done_flags}, 32'h0);
    @(negedge clk);
    re = 1'b0; reset = 1'b0;
    tick();
    check("post_rst_flag", {28'b0, done_flags}, 32'h1);
    check("post_rst_rvalid", {31'b0, rvalid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
